// File: rtl/prio_enc_queue.sv
// prio_enc_queue: registered successor of the 16:1 priority encoder.
// Level-sampled requests are captured into a sticky pending vector and
// issued one index per valid/ready transfer; each captured event is
// reported exactly once.
// Optional build macro: PRIO_ENC_RR_EN selects round-robin priority
// (search starts just below the last issued index); undefined gives
// fixed priority with bit N-1 highest.
module prio_enc_queue #(
    parameter int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic [N-1:0] pend,
    output logic         coalesce
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state_q;
    logic         out_valid_q;
    logic [W-1:0] out_idx_q;
    logic [N-1:0] out_onehot_q;
    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;
    logic         coalesce_q;
    logic         coalesce_d;

    logic [N-1:0] cand_s;
    logic         hit_s;
    logic [W-1:0] sel_s;
    logic         load_s;
    logic [N-1:0] clear_s;

`ifdef PRIO_ENC_RR_EN
    logic [W-1:0] lp_q;
`endif

    // One-hot decode of an index into an N-bit vector.
    function automatic logic [N-1:0] onehot_of(input logic [W-1:0] idx);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Winner selection among unmasked pending requests.
    always_comb begin
        cand_s = pend_q & ~mask;
        hit_s  = |cand_s;
        sel_s  = {W{1'b0}};
`ifdef PRIO_ENC_RR_EN
        // Walk from lowest to highest priority so the last hit wins;
        // distance 1 below lp is highest, lp itself is lowest.
        for (int i = N; i >= 1; i--) begin
            int k;
            k = int'(lp_q) - i;
            if (k < 0) begin
                k = k + N;
            end else begin
                k = k;
            end
            if (cand_s[W'(k)]) begin
                sel_s = W'(k);
            end else begin
                sel_s = sel_s;
            end
        end
`else
        // Ascending scan: the highest set index is written last.
        for (int i = 0; i < N; i++) begin
            if (cand_s[W'(i)]) begin
                sel_s = W'(i);
            end else begin
                sel_s = sel_s;
            end
        end
`endif
    end

    // Load decision and next pending/coalesce values.
    always_comb begin
        load_s = hit_s & (~out_valid_q | out_ready);
        if (load_s) begin
            clear_s = onehot_of(sel_s);
        end else begin
            clear_s = {N{1'b0}};
        end
        // A new req on the bit being cleared keeps it pending.
        pend_d     = (pend_q & ~clear_s) | req;
        coalesce_d = |(req & pend_q & ~clear_s);
    end

    // Issue FSM with registered output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_idx_q    <= {W{1'b0}};
            out_onehot_q <= {N{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit_s) begin
                        state_q      <= HOLD;
                        out_valid_q  <= 1'b1;
                        out_idx_q    <= sel_s;
                        out_onehot_q <= onehot_of(sel_s);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (hit_s) begin
                            out_idx_q    <= sel_s;
                            out_onehot_q <= onehot_of(sel_s);
                        end else begin
                            // out_idx keeps its stale value; only onehot is zeroed.
                            state_q      <= IDLE;
                            out_valid_q  <= 1'b0;
                            out_onehot_q <= {N{1'b0}};
                        end
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    out_valid_q  <= 1'b0;
                    out_onehot_q <= {N{1'b0}};
                end
            endcase
        end
    end

    // Sticky pending vector and merged-event pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= {N{1'b0}};
            coalesce_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            coalesce_q <= coalesce_d;
        end
    end

`ifdef PRIO_ENC_RR_EN
    // Round-robin pointer follows the last issued index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lp_q <= {W{1'b0}};
        end else if (load_s) begin
            lp_q <= sel_s;
        end
    end
`endif

    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_onehot = out_onehot_q;
    assign pend       = pend_q;
    assign coalesce   = coalesce_q;

endmodule
